word_server: RTL and testbench

- Responder end of the 4-bit-address / 16-bit-data fetch interface used by the periodic fetch unit.
- The fetch unit drives a3_a0 and samples d15_d0 every few clocks. This block holds a 16-word x 16-bit table and returns the addressed word, registered.
- The table is loaded at run time from an upstream byte producer over the team's standard dav_/rfd four-phase handshake.
- Each table write takes three bytes: address, high byte, low byte.

---
 rtl/word_server_pkg.sv | 29 ++
 rtl/word_server_table.sv | 43 ++++
 rtl/word_server.sv | 84 ++++++++
 tb/tb_word_server.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/word_server_pkg.sv
// Shared encodings and widths for the word server and its fetch-unit partner.
package word_server_pkg;

    localparam int ADDR_W = 4;
    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic {
        S_WAIT_DAV = 1'b0,
        S_WAIT_END = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        PH_ADDR = 2'd0,
        PH_HI   = 2'd1,
        PH_LO   = 2'd2
    } phase_t;

    // Address -> high byte -> low byte, then back to address.
    function automatic phase_t next_phase(input phase_t ph);
        case (ph)
            PH_ADDR: next_phase = PH_HI;
            PH_HI:   next_phase = PH_LO;
            default: next_phase = PH_ADDR;
        endcase
    endfunction

endpackage

// File: rtl/word_server_table.sv
// 16-entry word table: one write port, one registered read port (read-before-write).
module word_server_table
    import word_server_pkg::*;
#(
    parameter logic [WORD_W-1:0] INIT_WORD = '0
) (
    input  logic              clock,
    input  logic              reset_,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [WORD_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra,
    output logic [WORD_W-1:0] rd
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Every entry needs an async reset, so each is its own register.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WORD_W-1:0] entry_reg;

            always_ff @(posedge clock or negedge reset_) begin
                if (!reset_) begin
                    entry_reg <= INIT_WORD;
                end else if (we && (wa == ADDR_W'(gi))) begin
                    entry_reg <= wd;
                end
            end

            assign mem[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            rd <= INIT_WORD;
        end else begin
            rd <= mem[ra];
        end
    end

endmodule

// File: rtl/word_server.sv
// Word table responder: registered reads, loaded by 3-byte dav_/rfd handshake sequences.
module word_server
    import word_server_pkg::*;
#(
    parameter logic [WORD_W-1:0] INIT_WORD = 16'h0000
) (
    input  logic              clock,
    input  logic              reset_,
    input  logic [ADDR_W-1:0] a3_a0,
    output logic [WORD_W-1:0] d15_d0,
    input  logic              dav_,
    input  logic [BYTE_W-1:0] b7_b0,
    output logic              rfd,
    output logic              busy
);

    state_t            state_reg, state_next;
    phase_t            phase_reg, phase_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [BYTE_W-1:0] dhi_reg, dhi_next;
    logic              we;
    logic [WORD_W-1:0] wd;

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_reg <= S_WAIT_DAV;
            phase_reg <= PH_ADDR;
            addr_reg  <= '0;
            dhi_reg   <= '0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            addr_reg  <= addr_next;
            dhi_reg   <= dhi_next;
        end
    end

    // Bytes are consumed on the falling dav_ edge; the phase only moves once dav_ returns high.
    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        addr_next  = addr_reg;
        dhi_next   = dhi_reg;
        we         = 1'b0;
        wd         = {dhi_reg, b7_b0};
        case (state_reg)
            S_WAIT_DAV: begin
                if (!dav_) begin
                    state_next = S_WAIT_END;
                    case (phase_reg)
                        PH_ADDR: addr_next = b7_b0[ADDR_W-1:0];
                        PH_HI:   dhi_next  = b7_b0;
                        PH_LO:   we        = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_WAIT_END: begin
                if (dav_) begin
                    state_next = S_WAIT_DAV;
                    phase_next = next_phase(phase_reg);
                end
            end
            default: state_next = S_WAIT_DAV;
        endcase
    end

    assign rfd  = (state_reg == S_WAIT_DAV);
    // Busy covers the address-byte handshake as well as the data phases.
    assign busy = (phase_reg != PH_ADDR) || (state_reg == S_WAIT_END);

    word_server_table #(
        .INIT_WORD(INIT_WORD)
    ) u_table (
        .clock  (clock),
        .reset_ (reset_),
        .we     (we),
        .wa     (addr_reg),
        .wd     (wd),
        .ra     (a3_a0),
        .rd     (d15_d0)
    );

endmodule

// File: tb/tb_word_server.sv
// Directed bench for word_server: reset, loads, collision, stretched handshake, reset mid-load.
module tb_word_server;

    logic        clock;
    logic        reset_;
    logic [3:0]  a3_a0;
    logic [15:0] d15_d0;
    logic        dav_;
    logic [7:0]  b7_b0;
    logic        rfd;
    logic        busy;

    int checks;
    int failures;

    word_server #(.INIT_WORD(16'h0000)) dut (
        .clock  (clock),
        .reset_ (reset_),
        .a3_a0  (a3_a0),
        .d15_d0 (d15_d0),
        .dav_   (dav_),
        .b7_b0  (b7_b0),
        .rfd    (rfd),
        .busy   (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h required=%h", tag, obs, exp);
        end else begin
            $display("ok   %s value=%h", tag, obs);
        end
    endtask

    task automatic wait_rfd(input logic val, input string tag);
        for (int i = 0; i < 20 && rfd !== val; i++) @(negedge clock);
        check_eq(tag, {15'd0, rfd}, {15'd0, val});
    endtask

    task automatic send_byte(input logic [7:0] b);
        wait_rfd(1'b1, "rfd_ready");
        dav_  = 1'b0;
        b7_b0 = b;
        @(negedge clock);
        wait_rfd(1'b0, "rfd_ack");
        dav_ = 1'b1;
        @(negedge clock);
        wait_rfd(1'b1, "rfd_release");
    endtask

    task automatic read_word(input logic [3:0] a, input logic [15:0] exp, input string tag);
        @(negedge clock);
        a3_a0 = a;
        @(negedge clock);
        check_eq(tag, d15_d0, exp);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_   = 1'b1;
        a3_a0    = 4'd0;
        dav_     = 1'b1;
        b7_b0    = 8'h00;

        // Reset asserted between clock edges must act immediately
        #3 reset_ = 1'b0;
        #1;
        check_eq("rst_d", d15_d0, 16'h0000);
        check_eq("rst_rfd", {15'd0, rfd}, 16'd1);
        check_eq("rst_busy", {15'd0, busy}, 16'd0);
        @(negedge clock);
        reset_ = 1'b1;
        for (int i = 0; i < 16; i++) read_word(4'(i), 16'h0000, $sformatf("rst_entry%0d", i));

        // Basic load: 5 <- A37C
        send_byte(8'h05);
        check_eq("busy_after_addr", {15'd0, busy}, 16'd1);
        send_byte(8'hA3);
        check_eq("busy_after_hi", {15'd0, busy}, 16'd1);
        send_byte(8'h7C);
        check_eq("busy_after_lo", {15'd0, busy}, 16'd0);
        read_word(4'd5, 16'hA37C, "load_entry5");
        read_word(4'd4, 16'h0000, "load_entry4");

        // Collision: reading 9 while 9 is written shows the old word for one edge
        read_word(4'd9, 16'h0000, "coll_pre");
        send_byte(8'h09);
        send_byte(8'h12);
        dav_  = 1'b0;
        b7_b0 = 8'h34;
        @(posedge clock);
        #1 check_eq("coll_write_edge", d15_d0, 16'h0000);
        @(posedge clock);
        #1 check_eq("coll_next_edge", d15_d0, 16'h1234);
        @(negedge clock);
        dav_ = 1'b1;
        @(negedge clock);
        wait_rfd(1'b1, "coll_release");

        // Stretched dav_ on the high byte: exactly one byte consumed
        send_byte(8'h07);
        dav_  = 1'b0;
        b7_b0 = 8'hBE;
        begin
            int rises;
            rises = 0;
            for (int i = 0; i < 7; i++) begin
                @(negedge clock);
                if (rfd !== 1'b0) rises++;
            end
            check_eq("stretch_rfd_low", 16'(rises), 16'd0);
        end
        dav_ = 1'b1;
        @(negedge clock);
        wait_rfd(1'b1, "stretch_release");
        check_eq("stretch_busy_mid", {15'd0, busy}, 16'd1);
        send_byte(8'hEF);
        read_word(4'd7, 16'hBEEF, "stretch_entry7");

        // Reset mid-sequence discards the partial load and clears the table
        send_byte(8'h03);
        send_byte(8'hFF);
        #2 reset_ = 1'b0;
        #1;
        check_eq("midrst_busy", {15'd0, busy}, 16'd0);
        check_eq("midrst_rfd", {15'd0, rfd}, 16'd1);
        @(negedge clock);
        reset_ = 1'b1;
        read_word(4'd3, 16'h0000, "midrst_entry3");
        read_word(4'd5, 16'h0000, "midrst_entry5");
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        read_word(4'd2, 16'h1122, "midrst_entry2");
        read_word(4'd3, 16'h0000, "midrst_entry3b");

        // Fetch-unit style table: high nibble of address byte ignored
        send_byte(8'hF0);
        send_byte(8'h43);
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h00);
        send_byte(8'hFF);
        read_word(4'd0, 16'h43A5, "fetch_entry0");
        read_word(4'd4, 16'h00FF, "fetch_entry4");
        read_word(4'd0, 16'h43A5, "fetch_entry0b");
        read_word(4'd15, 16'h0000, "fetch_entry15");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
